approx_arbiter: RTL and testbench
=================================

APPROX_ARBITER -- requirements
Module: approx_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent in WAIT before a job is aborted; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 req0_i / req1_i  input  1 each  requester 0/1 job request; level, held until the matching ack.
REQ-005 x0_i / x1_i  input  16 each  requester 0/1 operand, Q4.12; stable while the matching req is high.
REQ-006 nIt0_i / nIt1_i  input  3 each  requester 0/1 iteration count, forwarded unchanged to the core.
REQ-007 ack0_o / ack1_o  output  1 each  one-cycle pulse: job accepted; requester may drop req and change its operand.
REQ-008 valid0_o / valid1_o  output  1 each  one-cycle pulse: y_o holds that requester's result.
REQ-009 err0_o / err1_o  output  1 each  one-cycle pulse: that requester's job was aborted on timeout.
REQ-010 y_o  output  16  last captured core result, held between captures.
REQ-011 busy_o  output  1  high whenever the state is not IDLE.
REQ-012 core_start_o  output  1  start pulse to the shared approximation core.
REQ-013 core_x_o  output  16 / core_nIt_o  output  3: operand and iteration count to the core, held from grant until the next grant.
REQ-014 core_rst_o  output  1  core reset, asserted for one cycle on timeout.
REQ-015 core_busy_i  input  1 / core_valid_i  input  1 / core_y_i  input  16: core status and result.

Function
REQ-016 The block SHALL implement states IDLE, START, WAIT, ABORT; all outputs are registered.
REQ-017 IDLE: if any req is sampled high, go to START on the next edge, latch the winner's x/nIt into core_x_o/core_nIt_o, and assert the winner's ack for the first START cycle only.
REQ-018 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; after reset requester 0 has priority.
REQ-019 A single requesting input SHALL always win, regardless of priority.
REQ-020 START lasts exactly one cycle with core_start_o=1, then WAIT; core_start_o SHALL be 0 in all other states.
REQ-021 WAIT: on the first cycle with core_valid_i=1, capture core_y_i into y_o, pulse the owner's valid on the next cycle, toggle priority away from the owner, and return to IDLE.
REQ-022 Each WAIT cycle SHALL increment a 16-bit counter cleared on entry to WAIT; if it reaches TIMEOUT without core_valid_i, go to ABORT.
REQ-023 core_valid_i=1 in the same cycle the counter reaches TIMEOUT SHALL count as completion, not as a timeout.
REQ-024 ABORT lasts one cycle with core_rst_o=1 and the owner's err pulsed, y_o unchanged, priority toggled, then IDLE.
REQ-025 core_valid_i outside WAIT SHALL be ignored; y_o and the valid outputs are not affected.
REQ-026 core_busy_i is status only and SHALL NOT affect state transitions.
REQ-027 At most one of ack/valid/err SHALL be high per cycle across both requesters.
REQ-028 A req still high in IDLE after its ack SHALL be treated as a new job, arbitrated normally.
REQ-029 Minimum turnaround SHALL be: ack at cycle N+1, core_start_o at N+1, valid at WAIT-capture edge +1, IDLE available on the same edge.

Reset
REQ-030 With rst high, state = IDLE, priority = requester 0, counter = 0, y_o/core_x_o = 0, core_nIt_o = 0, and all pulses plus busy_o = 0, asynchronously.
REQ-031 With rst high, core_rst_o SHALL be 1, so the core resets together with the arbiter.
REQ-032 When rst is asserted mid-job, the job SHALL be dropped silently, with no valid or err pulse after release.

Verification
REQ-033 Single request, req0=1, x0=16'd1638 (0.4), nIt0=7, core returns valid with y=16'd10240 after 20 cycles -> ack0 one pulse, one start pulse, y_o=10240, valid0 one pulse, busy_o low afterwards.
REQ-034 req0 and req1 held high for 4 jobs -> grants in order 0,1,0,1; each ack is followed by exactly one valid to the same requester.
REQ-035 TIMEOUT=8, core never returns valid -> after 8 WAIT cycles: err0 pulse, core_rst_o pulse, y_o unchanged, IDLE; the next req1 is granted normally.
REQ-036 core_valid_i arrives on the cycle the counter reaches TIMEOUT -> valid pulse, no err.
REQ-037 Spurious core_valid_i=1 with y=16'hFFFF in IDLE -> y_o unchanged, no valid pulse.
REQ-038 rst asserted during WAIT, then released -> all outputs at reset values, no pulses, priority back to requester 0.

Source files
------------

// File: rtl/approx_arbiter.sv
// ---------------------------------------------------------------------------
// approx_arbiter
//
// Shares one iterative approximation core between two requesters. A job is
// granted from IDLE, the core is started for one cycle, and the arbiter then
// waits for the core result. If the result does not arrive within TIMEOUT
// WAIT cycles, the core is reset for one cycle and the owner gets an error
// pulse instead of a result.
//
// Parameters
//   TIMEOUT       maximum number of WAIT cycles before the job is aborted
//                 (1..65535)
//
// Ports
//   clk           single clock, rising edge active
//   rst           asynchronous active-high reset
//   req0_i/req1_i job request (level, held until the matching ack)
//   x0_i/x1_i     Q4.12 operand of requester 0/1
//   nIt0_i/nIt1_i iteration count of requester 0/1
//   ack0_o/ack1_o one-cycle pulse: job accepted
//   valid0_o/1_o  one-cycle pulse: y_o holds that requester's result
//   err0_o/err1_o one-cycle pulse: that requester's job timed out
//   y_o           last captured core result, held between captures
//   busy_o        high whenever the arbiter is not in IDLE
//   core_start_o  start pulse to the core
//   core_x_o      operand to the core, held from grant to the next grant
//   core_nIt_o    iteration count to the core, held like core_x_o
//   core_rst_o    core reset: high during arbiter reset and on timeout
//   core_busy_i   core status (informational only)
//   core_valid_i  core result strobe
//   core_y_i      core result
// ---------------------------------------------------------------------------
module approx_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_i,
   input  logic        req1_i,
   input  logic [15:0] x0_i,
   input  logic [15:0] x1_i,
   input  logic [2:0]  nIt0_i,
   input  logic [2:0]  nIt1_i,
   output logic        ack0_o,
   output logic        ack1_o,
   output logic        valid0_o,
   output logic        valid1_o,
   output logic        err0_o,
   output logic        err1_o,
   output logic [15:0] y_o,
   output logic        busy_o,
   output logic        core_start_o,
   output logic [15:0] core_x_o,
   output logic [2:0]  core_nIt_o,
   output logic        core_rst_o,
   input  logic        core_busy_i,
   input  logic        core_valid_i,
   input  logic [15:0] core_y_i
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      ABORT = 2'd3
   } state_t;

   localparam logic [15:0] TIMEOUT_C = TIMEOUT[15:0];

   // FSM state and bookkeeping
   state_t      state_r;
   logic        prio_r;       // requester that wins when both request
   logic        owner_r;      // requester that owns the running job
   logic [15:0] cnt_r;        // WAIT cycles elapsed for the running job

   // registered outputs
   logic        ack0_r;
   logic        ack1_r;
   logic        valid0_r;
   logic        valid1_r;
   logic        err0_r;
   logic        err1_r;
   logic [15:0] y_r;
   logic        busy_r;
   logic        core_start_r;
   logic [15:0] core_x_r;
   logic [2:0]  core_nit_r;
   logic        core_rst_r;

   // combinational helpers
   logic        req_any_s;
   logic        winner_s;
   logic [15:0] win_x_s;
   logic [2:0]  win_nit_s;
   logic [15:0] cnt_inc_s;
   logic        timeout_hit_s;

   // Core busy is status only; it never steers the state machine.
   logic        unused_core_busy_s;
   assign unused_core_busy_s = core_busy_i;

   // Round-robin arbitration: a lone requester always wins, a tie goes to
   // the requester not served last.
   always_comb begin
      req_any_s = req0_i | req1_i;
      if (req0_i && req1_i) begin
         winner_s = prio_r;
      end else if (req1_i) begin
         winner_s = 1'b1;
      end else begin
         winner_s = 1'b0;
      end
      if (winner_s) begin
         win_x_s   = x1_i;
         win_nit_s = nIt1_i;
      end else begin
         win_x_s   = x0_i;
         win_nit_s = nIt0_i;
      end
   end

   // Timeout detection: the current WAIT cycle is cycle number cnt_r + 1.
   always_comb begin
      cnt_inc_s = cnt_r + 16'd1;
      if (cnt_inc_s == TIMEOUT_C) begin
         timeout_hit_s = 1'b1;
      end else begin
         timeout_hit_s = 1'b0;
      end
   end

   // Main state machine with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         prio_r       <= 1'b0;
         owner_r      <= 1'b0;
         cnt_r        <= 16'd0;
         ack0_r       <= 1'b0;
         ack1_r       <= 1'b0;
         valid0_r     <= 1'b0;
         valid1_r     <= 1'b0;
         err0_r       <= 1'b0;
         err1_r       <= 1'b0;
         y_r          <= 16'd0;
         busy_r       <= 1'b0;
         core_start_r <= 1'b0;
         core_x_r     <= 16'd0;
         core_nit_r   <= 3'd0;
         // the core is held in reset together with the arbiter
         core_rst_r   <= 1'b1;
      end else begin
         // every pulse output defaults low and is raised for one cycle only
         ack0_r       <= 1'b0;
         ack1_r       <= 1'b0;
         valid0_r     <= 1'b0;
         valid1_r     <= 1'b0;
         err0_r       <= 1'b0;
         err1_r       <= 1'b0;
         core_start_r <= 1'b0;
         core_rst_r   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req_any_s) begin
                  state_r      <= START;
                  owner_r      <= winner_s;
                  core_x_r     <= win_x_s;
                  core_nit_r   <= win_nit_s;
                  ack0_r       <= ~winner_s;
                  ack1_r       <= winner_s;
                  core_start_r <= 1'b1;
                  busy_r       <= 1'b1;
               end else begin
                  busy_r       <= 1'b0;
               end
            end
            START: begin
               state_r <= WAIT;
               cnt_r   <= 16'd0;
               busy_r  <= 1'b1;
            end
            WAIT: begin
               // a result in the timeout cycle still counts as completion
               if (core_valid_i) begin
                  state_r  <= IDLE;
                  y_r      <= core_y_i;
                  valid0_r <= ~owner_r;
                  valid1_r <= owner_r;
                  prio_r   <= ~owner_r;
                  busy_r   <= 1'b0;
               end else if (timeout_hit_s) begin
                  state_r    <= ABORT;
                  core_rst_r <= 1'b1;
                  err0_r     <= ~owner_r;
                  err1_r     <= owner_r;
                  busy_r     <= 1'b1;
               end else begin
                  cnt_r  <= cnt_inc_s;
                  busy_r <= 1'b1;
               end
            end
            ABORT: begin
               state_r <= IDLE;
               prio_r  <= ~owner_r;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign ack0_o       = ack0_r;
   assign ack1_o       = ack1_r;
   assign valid0_o     = valid0_r;
   assign valid1_o     = valid1_r;
   assign err0_o       = err0_r;
   assign err1_o       = err1_r;
   assign y_o          = y_r;
   assign busy_o       = busy_r;
   assign core_start_o = core_start_r;
   assign core_x_o     = core_x_r;
   assign core_nIt_o   = core_nit_r;
   assign core_rst_o   = core_rst_r;

endmodule

// File: tb/tb_approx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_approx_arbiter
//
// Two arbiter instances: inst 0 with TIMEOUT=255, inst 1 with TIMEOUT=8.
// Directed stimulus pushes the expected ack/valid/err events (with operand,
// result and ack-relative cycle distance) into a per-instance queue; a
// monitor pops and compares whenever an instance raises a pulse. A small
// core model answers each core_start after a scripted latency.
// ---------------------------------------------------------------------------
module tb_approx_arbiter;

   typedef struct {
      int          kind;   // 0 ack, 1 valid, 2 err
      int          id;
      logic [15:0] x;
      logic [2:0]  nit;
      logic [15:0] y;
      int          dt;     // cycles from ack to valid/err
   } ev_t;

   typedef struct {
      int          lat;    // WAIT cycle carrying core_valid; 0 = never
      logic [15:0] y;
   } rsp_t;

   logic        clk;
   logic        rst;
   logic        req0 [2];
   logic        req1 [2];
   logic [15:0] x0 [2];
   logic [15:0] x1 [2];
   logic [2:0]  nit0 [2];
   logic [2:0]  nit1 [2];
   logic        ack0 [2];
   logic        ack1 [2];
   logic        valid0 [2];
   logic        valid1 [2];
   logic        err0 [2];
   logic        err1 [2];
   logic [15:0] y [2];
   logic        busy [2];
   logic        core_start [2];
   logic [15:0] core_x [2];
   logic [2:0]  core_nit [2];
   logic        core_rst [2];
   logic        cb [2];
   logic        cv [2];
   logic [15:0] cy [2];

   int   vectors;
   int   fails;
   int   cyc;
   int   ack_t [2];
   int   ack_cnt [2][2];
   int   start_cnt [2];
   int   rstp_cnt [2];
   int   spur_cnt [2];
   ev_t  expq0 [$];
   ev_t  expq1 [$];
   rsp_t rq0 [$];
   rsp_t rq1 [$];

   approx_arbiter #(.TIMEOUT(255)) dut0 (
      .clk(clk), .rst(rst),
      .req0_i(req0[0]), .req1_i(req1[0]), .x0_i(x0[0]), .x1_i(x1[0]),
      .nIt0_i(nit0[0]), .nIt1_i(nit1[0]),
      .ack0_o(ack0[0]), .ack1_o(ack1[0]), .valid0_o(valid0[0]), .valid1_o(valid1[0]),
      .err0_o(err0[0]), .err1_o(err1[0]), .y_o(y[0]), .busy_o(busy[0]),
      .core_start_o(core_start[0]), .core_x_o(core_x[0]), .core_nIt_o(core_nit[0]),
      .core_rst_o(core_rst[0]), .core_busy_i(cb[0]), .core_valid_i(cv[0]), .core_y_i(cy[0])
   );

   approx_arbiter #(.TIMEOUT(8)) dut1 (
      .clk(clk), .rst(rst),
      .req0_i(req0[1]), .req1_i(req1[1]), .x0_i(x0[1]), .x1_i(x1[1]),
      .nIt0_i(nit0[1]), .nIt1_i(nit1[1]),
      .ack0_o(ack0[1]), .ack1_o(ack1[1]), .valid0_o(valid0[1]), .valid1_o(valid1[1]),
      .err0_o(err0[1]), .err1_o(err1[1]), .y_o(y[1]), .busy_o(busy[1]),
      .core_start_o(core_start[1]), .core_x_o(core_x[1]), .core_nIt_o(core_nit[1]),
      .core_rst_o(core_rst[1]), .core_busy_i(cb[1]), .core_valid_i(cv[1]), .core_y_i(cy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s inst%0d: got %0h expected %0h (cycle %0d)", nm, k, act, exp, cyc);
      end
   endtask

   function automatic ev_t mk(input int kind, input int id, input logic [15:0] x,
                              input logic [2:0] nit, input logic [15:0] yv, input int dt);
      ev_t e;
      e.kind = kind; e.id = id; e.x = x; e.nit = nit; e.y = yv; e.dt = dt;
      return e;
   endfunction

   function automatic rsp_t mr(input int lat, input logic [15:0] yv);
      rsp_t r;
      r.lat = lat; r.y = yv;
      return r;
   endfunction

   task automatic push_exp(input int k, input ev_t e);
      if (k == 0) expq0.push_back(e); else expq1.push_back(e);
   endtask

   function automatic int qsize(input int k);
      return (k == 0) ? expq0.size() : expq1.size();
   endfunction

   task automatic pop_exp(input int k, output ev_t e, output bit ok);
      ok = 1'b0;
      e  = mk(-1, -1, 16'd0, 3'd0, 16'd0, 0);
      if (k == 0 && expq0.size() > 0) begin e = expq0.pop_front(); ok = 1'b1; end
      if (k == 1 && expq1.size() > 0) begin e = expq1.pop_front(); ok = 1'b1; end
   endtask

   task automatic pop_rsp(input int k, output rsp_t r);
      r = mr(0, 16'd0);
      if (k == 0 && rq0.size() > 0) r = rq0.pop_front();
      if (k == 1 && rq1.size() > 0) r = rq1.pop_front();
   endtask

   // Scoreboard monitor for one instance, sampled on the falling edge.
   task automatic mon(input int k);
      int  n;
      int  kind;
      int  id;
      ev_t e;
      bit  ok;
      n = int'(ack0[k]) + int'(ack1[k]) + int'(valid0[k]) + int'(valid1[k])
        + int'(err0[k]) + int'(err1[k]);
      if (core_start[k]) start_cnt[k]++;
      if (core_start[k] || ack0[k] || ack1[k])
         check("start_with_ack", k, {31'd0, core_start[k]}, {31'd0, ack0[k] | ack1[k]});
      if (n > 1) begin
         check("one_pulse", k, n, 1);
      end else if (n == 1) begin
         kind = (ack0[k] || ack1[k]) ? 0 : ((valid0[k] || valid1[k]) ? 1 : 2);
         id   = (ack1[k] || valid1[k] || err1[k]) ? 1 : 0;
         pop_exp(k, e, ok);
         check("expected_event", k, {31'd0, ok}, 32'd1);
         if (ok) begin
            check("event_kind", k, kind, e.kind);
            check("event_id", k, id, e.id);
            if (kind == 0) begin
               check("core_x", k, {16'd0, core_x[k]}, {16'd0, e.x});
               check("core_nit", k, {29'd0, core_nit[k]}, {29'd0, e.nit});
               ack_t[k] = cyc;
               ack_cnt[k][id]++;
            end else if (kind == 1) begin
               check("y_result", k, {16'd0, y[k]}, {16'd0, e.y});
               check("valid_latency", k, cyc - ack_t[k], e.dt);
            end else begin
               check("y_unchanged", k, {16'd0, y[k]}, {16'd0, e.y});
               check("core_rst_at_err", k, {31'd0, core_rst[k]}, 32'd1);
               check("err_latency", k, cyc - ack_t[k], e.dt);
               rstp_cnt[k]++;
            end
         end
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            mon(0);
            mon(1);
         end
      end
   end

   // Core model: answers core_start after the scripted WAIT-cycle latency,
   // and emits spurious result strobes on request.
   initial begin : core_model
      int          pend [2];
      int          spur_seen [2];
      logic [15:0] py [2];
      rsp_t        r;
      for (int k = 0; k < 2; k++) begin
         pend[k] = 0; spur_seen[k] = 0; py[k] = 16'd0;
         cv[k] = 1'b0; cy[k] = 16'd0; cb[k] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (core_start[k]) begin
               pop_rsp(k, r);
               pend[k] = r.lat;
               py[k]   = r.y;
            end
         end
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            cv[k] = 1'b0;
            if (pend[k] > 0) begin
               pend[k]--;
               if (pend[k] == 0) begin
                  cv[k] = 1'b1;
                  cy[k] = py[k];
               end
            end else if (spur_cnt[k] != spur_seen[k]) begin
               cv[k] = 1'b1;
               cy[k] = 16'hFFFF;
               spur_seen[k]++;
            end
            cb[k] = (pend[k] > 0);
         end
      end
   end

   task automatic run_req(input int k, input int id, input logic [15:0] x, input logic [2:0] nit);
      int base;
      base = ack_cnt[k][id];
      if (id == 0) begin req0[k] = 1'b1; x0[k] = x; nit0[k] = nit; end
      else         begin req1[k] = 1'b1; x1[k] = x; nit1[k] = nit; end
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (ack_cnt[k][id] != base) break;
      end
      check("ack_seen", k, ack_cnt[k][id] - base, 1);
      if (id == 0) req0[k] = 1'b0; else req1[k] = 1'b0;
   endtask

   task automatic wait_drain(input int k, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (qsize(k) == 0 && !busy[k]) break;
      end
      check("drain_queue", k, qsize(k), 0);
      check("drain_busy", k, {31'd0, busy[k]}, 32'd0);
   endtask

   task automatic check_reset_values(input int k);
      check("rst_busy", k, {31'd0, busy[k]}, 32'd0);
      check("rst_y", k, {16'd0, y[k]}, 32'd0);
      check("rst_core_x", k, {16'd0, core_x[k]}, 32'd0);
      check("rst_core_nit", k, {29'd0, core_nit[k]}, 32'd0);
      check("rst_core_rst", k, {31'd0, core_rst[k]}, 32'd1);
      check("rst_pulses", k, {26'd0, ack0[k], ack1[k], valid0[k], valid1[k], err0[k], err1[k]}, 32'd0);
      check("rst_start", k, {31'd0, core_start[k]}, 32'd0);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not reach the end, got timeout expected finish");
      $fatal(1);
   end

   initial begin : stimulus
      int b0;
      int b1;
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         req0[k] = 1'b0; req1[k] = 1'b0; x0[k] = 16'd0; x1[k] = 16'd0;
         nit0[k] = 3'd0; nit1[k] = 3'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_reset_values(0);
      check_reset_values(1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("core_rst_released", 0, {31'd0, core_rst[0]}, 32'd0);

      // single request, core answers in WAIT cycle 20
      rq0.push_back(mr(20, 16'd10240));
      push_exp(0, mk(0, 0, 16'd1638, 3'd7, 16'd0, 0));
      push_exp(0, mk(1, 0, 16'd0, 3'd0, 16'd10240, 21));
      run_req(0, 0, 16'd1638, 3'd7);
      wait_drain(0, 60);
      check("single_y", 0, {16'd0, y[0]}, 32'd10240);
      check("single_starts", 0, start_cnt[0], 1);

      // spurious core result while IDLE must be ignored
      spur_cnt[0] = spur_cnt[0] + 3;
      repeat (6) @(posedge clk);
      #1;
      check("spurious_y", 0, {16'd0, y[0]}, 32'd10240);
      check("spurious_busy", 0, {31'd0, busy[0]}, 32'd0);
      check("spurious_starts", 0, start_cnt[0], 1);

      // TIMEOUT=8: result in the 8th WAIT cycle is a completion
      rq1.push_back(mr(8, 16'h1234));
      push_exp(1, mk(0, 1, 16'h2000, 3'd5, 16'd0, 0));
      push_exp(1, mk(1, 1, 16'd0, 3'd0, 16'h1234, 9));
      run_req(1, 1, 16'h2000, 3'd5);
      wait_drain(1, 40);
      check("boundary_y", 1, {16'd0, y[1]}, 32'h1234);
      check("boundary_no_err", 1, rstp_cnt[1], 0);

      // TIMEOUT=8: core never answers -> abort after 8 WAIT cycles
      rq1.push_back(mr(0, 16'd0));
      push_exp(1, mk(0, 0, 16'h0100, 3'd3, 16'd0, 0));
      push_exp(1, mk(2, 0, 16'd0, 3'd0, 16'h1234, 9));
      run_req(1, 0, 16'h0100, 3'd3);
      wait_drain(1, 40);
      check("abort_core_rst_pulses", 1, rstp_cnt[1], 1);
      check("abort_core_rst_low", 1, {31'd0, core_rst[1]}, 32'd0);
      check("abort_y", 1, {16'd0, y[1]}, 32'h1234);

      // next request after the abort is served normally
      rq1.push_back(mr(3, 16'h0ABC));
      push_exp(1, mk(0, 1, 16'h3000, 3'd2, 16'd0, 0));
      push_exp(1, mk(1, 1, 16'd0, 3'd0, 16'h0ABC, 4));
      run_req(1, 1, 16'h3000, 3'd2);
      wait_drain(1, 40);
      check("after_abort_y", 1, {16'd0, y[1]}, 32'h0ABC);

      // reset in the middle of a WAIT: job dropped silently
      rq0.push_back(mr(0, 16'd0));
      push_exp(0, mk(0, 0, 16'h0777, 3'd1, 16'd0, 0));
      run_req(0, 0, 16'h0777, 3'd1);
      repeat (4) @(posedge clk);
      #1;
      check("midjob_busy", 0, {31'd0, busy[0]}, 32'd1);
      rst = 1'b1;
      #1;
      check_reset_values(0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_busy", 0, {31'd0, busy[0]}, 32'd0);
      check("post_rst_y", 0, {16'd0, y[0]}, 32'd0);
      check("post_rst_core_rst", 0, {31'd0, core_rst[0]}, 32'd0);
      check("post_rst_queue", 0, qsize(0), 0);

      // both requesters held high for four jobs -> grants 0,1,0,1
      rq0.push_back(mr(2, 16'h1111));
      rq0.push_back(mr(2, 16'h2222));
      rq0.push_back(mr(2, 16'h3333));
      rq0.push_back(mr(2, 16'h4444));
      push_exp(0, mk(0, 0, 16'h0A00, 3'd2, 16'd0, 0));
      push_exp(0, mk(1, 0, 16'd0, 3'd0, 16'h1111, 3));
      push_exp(0, mk(0, 1, 16'h0B00, 3'd6, 16'd0, 0));
      push_exp(0, mk(1, 1, 16'd0, 3'd0, 16'h2222, 3));
      push_exp(0, mk(0, 0, 16'h0A00, 3'd2, 16'd0, 0));
      push_exp(0, mk(1, 0, 16'd0, 3'd0, 16'h3333, 3));
      push_exp(0, mk(0, 1, 16'h0B00, 3'd6, 16'd0, 0));
      push_exp(0, mk(1, 1, 16'd0, 3'd0, 16'h4444, 3));
      b0 = ack_cnt[0][0];
      b1 = ack_cnt[0][1];
      x0[0] = 16'h0A00; nit0[0] = 3'd2; req0[0] = 1'b1;
      x1[0] = 16'h0B00; nit1[0] = 3'd6; req1[0] = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (ack_cnt[0][0] - b0 >= 2) req0[0] = 1'b0;
         if (ack_cnt[0][1] - b1 >= 2) req1[0] = 1'b0;
         if (!req0[0] && !req1[0]) break;
      end
      req0[0] = 1'b0;
      req1[0] = 1'b0;
      check("rr_acks_req0", 0, ack_cnt[0][0] - b0, 2);
      check("rr_acks_req1", 0, ack_cnt[0][1] - b1, 2);
      wait_drain(0, 40);
      check("rr_last_y", 0, {16'd0, y[0]}, 32'h4444);

      repeat (5) @(posedge clk);
      #1;
      check("final_queue", 0, qsize(0), 0);
      check("final_queue", 1, qsize(1), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
